// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions for the CBC/ECB stream encryptor: widths, FSM states, S-box and Rcon.
// Pure constants and functions; no timing or flow control lives here.
package aes128_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        ENCRYPT,
        OUTPUT,
        FINISH
    } state_t;

    // Row 0 (entries 0x00..0x0f) sits in the most-significant bytes, so entry b is element 255-b.
    localparam logic [255:0][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [9:0][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[~b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, one round per cycle with on-the-fly key expansion.
// done pulses 11 cycles after start (load/AddRoundKey + 10 rounds); no backpressure, result holds until next start.
module aes128_iter_core
    import aes128_pkg::*;
#(
    parameter int CORE_ROUNDS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AES_KEY_W-1:0]   key,
    input  logic [AES_BLOCK_W-1:0] block_in,
    output logic [AES_BLOCK_W-1:0] result,
    output logic                   done
);

    localparam logic [3:0] LAST_RND = 4'(CORE_ROUNDS);

    logic [AES_BLOCK_W-1:0] r_state;
    logic [AES_KEY_W-1:0]   r_rkey;
    logic [3:0]             r_rnd;
    logic                   r_active;
    logic                   r_done;

    logic [AES_BLOCK_W-1:0] w_round_out;
    logic [AES_KEY_W-1:0]   w_rkey_nxt;

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n lives at s[127-8n -: 8]; column c holds bytes 4c..4c+3 and row r is the offset within it.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_word(s[127 - 32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // r_rkey always holds the round key for the round r_rnd is about to apply.
    always_comb begin
        w_rkey_nxt  = key_step(r_rkey, rcon(r_rnd));
        w_round_out = shift_rows(sub_bytes(r_state));
        if (r_rnd != LAST_RND) w_round_out = mix_columns(w_round_out);
        w_round_out = w_round_out ^ r_rkey;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= '0;
            r_rkey   <= '0;
            r_rnd    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state  <= block_in;
                r_rkey   <= key;
                r_rnd    <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                r_rkey <= w_rkey_nxt;
                r_rnd  <= r_rnd + 4'd1;
                if (r_rnd == 4'd0) r_state <= r_state ^ r_rkey;
                else               r_state <= w_round_out;
                if (r_rnd == LAST_RND) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign result = r_state;
    assign done   = r_done;

endmodule

// File: rtl/aes128_cbc_stream.sv
// AES-128 ECB/CBC message encryptor over valid/ready block streams, one block in flight at a time.
// out_valid rises 12 edges after input acceptance; cipher_text holds while out_ready is low, in_ready only in WAIT_IN.
module aes128_cbc_stream
    import aes128_pkg::*;
#(
    parameter int BLK_CNT_W   = 8,
    parameter int CORE_ROUNDS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode_cbc,
    input  logic [AES_KEY_W-1:0]   key,
    input  logic [AES_BLOCK_W-1:0] vector,
    input  logic [BLK_CNT_W-1:0]   num_blocks,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] plain_text,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] cipher_text,
    output logic                   busy,
    output logic                   done
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AES_KEY_W-1:0]   r_key;
    logic [AES_BLOCK_W-1:0] r_chain;
    logic [AES_BLOCK_W-1:0] r_cipher;
    logic                   r_mode;
    logic [BLK_CNT_W-1:0]   r_remaining;

    logic                   w_start_msg;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_core_done;
    logic [AES_BLOCK_W-1:0] w_core_in;
    logic [AES_BLOCK_W-1:0] w_core_result;

    assign w_start_msg = (r_state == IDLE) && start && (num_blocks != '0);
    assign w_in_hs     = in_valid && in_ready;
    assign w_out_hs    = out_valid && out_ready;
    assign w_core_in   = r_mode ? (plain_text ^ r_chain) : plain_text;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = (num_blocks != '0) ? WAIT_IN : FINISH;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_state_nxt = ENCRYPT;
            end
            ENCRYPT: begin
                busy = 1'b1;
                if (w_core_done) w_state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // Terminal test on 1 rather than 0 so the counter never wraps.
                if (out_ready) w_state_nxt = (r_remaining == BLK_CNT_W'(1)) ? FINISH : WAIT_IN;
            end
            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key       <= '0;
            r_chain     <= '0;
            r_cipher    <= '0;
            r_mode      <= 1'b0;
            r_remaining <= '0;
        end else begin
            if (w_start_msg) begin
                r_key       <= key;
                r_chain     <= vector;
                r_mode      <= mode_cbc;
                r_remaining <= num_blocks;
            end
            if ((r_state == ENCRYPT) && w_core_done) begin
                r_cipher <= w_core_result;
                r_chain  <= w_core_result;
            end
            if (w_out_hs) r_remaining <= r_remaining - BLK_CNT_W'(1);
        end
    end

    aes128_iter_core #(
        .CORE_ROUNDS (CORE_ROUNDS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (w_in_hs),
        .key      (r_key),
        .block_in (w_core_in),
        .result   (w_core_result),
        .done     (w_core_done)
    );

    assign cipher_text = r_cipher;

endmodule

// File: tb/tb_aes128_cbc_stream.sv
// Self-checking bench for aes128_cbc_stream: known-answer table, corner sequences, random messages vs a byte-level AES model.
module tb_aes128_cbc_stream;

    localparam int BW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           mode_cbc;
    logic [127:0]   key;
    logic [127:0]   vector;
    logic [BW-1:0]  num_blocks;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   plain_text;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   cipher_text;
    logic           busy;
    logic           done;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [7:0]     sb [256];
    logic [127:0]   q_pt [$];
    logic [127:0]   q_exp [$];
    bit             quiet_ok;

    typedef struct {
        logic         mode;
        logic [127:0] key;
        logic [127:0] iv;
        int           nblk;
        int           stall;
        logic [127:0] pt0;
        logic [127:0] pt1;
        logic [127:0] ct0;
        logic [127:0] ct1;
    } vec_t;

    vec_t tbl [4];

    aes128_cbc_stream #(
        .BLK_CNT_W   (BW),
        .CORE_ROUNDS (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode_cbc    (mode_cbc),
        .key         (key),
        .vector      (vector),
        .num_blocks  (num_blocks),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plain_text  (plain_text),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: AES on a 4x4 byte matrix ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   w [44][4];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[127 - 8*(4*i + j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp[0] = sb[w[i-1][1]] ^ rc;
                tmp[1] = sb[w[i-1][2]];
                tmp[2] = sb[w[i-1][3]];
                tmp[3] = sb[w[i-1][0]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd + c][r];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ct[127 - 8*(4*c + r) -: 8] = s[r][c];
        return ct;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic prep_random(input logic m, input logic [127:0] k, input logic [127:0] iv, input int n);
        logic [127:0] ch, p, c;
        q_pt.delete(); q_exp.delete();
        ch = iv;
        for (int b = 0; b < n; b++) begin
            p  = rand128();
            c  = aes_enc(k, m ? (p ^ ch) : p);
            ch = c;
            q_pt.push_back(p);
            q_exp.push_back(c);
        end
    endtask

    // ---------------- message driver with built-in checks ----------------
    task automatic run_msg(input logic m, input logic [127:0] k, input logic [127:0] iv, input int n,
                           input int stall, input int gap, input bit poke, input string tag);
        int           lat;
        int           w;
        bit           ok;
        logic [127:0] held;
        @(negedge clk);
        mode_cbc = m; key = k; vector = iv; num_blocks = BW'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = rand128(); vector = rand128(); mode_cbc = 1'($urandom); num_blocks = BW'($urandom);
        if (n == 0) begin
            check_val({tag, " done"}, done, 1);
            check_val({tag, " busy"}, busy, 0);
            ok = 1;
            repeat (20) begin
                @(negedge clk);
                if (in_ready || out_valid || done) ok = 0;
            end
            check_val({tag, " quiet"}, ok, 1);
            return;
        end
        check_val({tag, " busy"}, busy, 1);
        for (int b = 0; b < n; b++) begin
            repeat (gap) @(negedge clk);
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            check_val($sformatf("%s b%0d in_ready", tag, b), in_ready, 1);
            if (!in_ready) return;
            in_valid = 1'b1; plain_text = q_pt[b];
            @(negedge clk);
            in_valid = 1'b0; plain_text = rand128();
            lat = 0; ok = 1;
            while (!out_valid && lat < 40) begin
                if (in_ready) ok = 0;
                if (poke && lat == 4) begin
                    start = 1'b1; key = rand128(); vector = rand128();
                    mode_cbc = ~m; num_blocks = BW'(7);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
            start = 1'b0;
            check_val($sformatf("%s b%0d latency", tag, b), 128'(lat), 128'(12));
            check_val($sformatf("%s b%0d no in_ready", tag, b), ok, 1);
            if (!out_valid) return;
            held = cipher_text; ok = 1;
            repeat (stall) begin
                @(negedge clk);
                if (!out_valid || in_ready || cipher_text !== held) ok = 0;
            end
            if (stall > 0) check_val($sformatf("%s b%0d hold", tag, b), ok, 1);
            check_val($sformatf("%s b%0d ct", tag, b), cipher_text, q_exp[b]);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_val({tag, " done"}, done, 1);
        check_val({tag, " busy end"}, busy, 0);
        check_val({tag, " valid end"}, out_valid, 0);
        @(negedge clk);
        check_val({tag, " done pulse"}, done, 0);
    endtask

    initial begin
        logic         m;
        logic [127:0] k, iv;
        int           n;

        reset = 1'b1; start = 1'b0; mode_cbc = 1'b0; key = '0; vector = '0;
        num_blocks = '0; in_valid = 1'b0; plain_text = '0; out_ready = 1'b0;

        build_sbox();

        tbl[0] = '{mode: 1'b0, key: 128'h000102030405060708090a0b0c0d0e0f, iv: 128'h0, nblk: 1, stall: 0,
                   pt0: 128'h00112233445566778899aabbccddeeff, pt1: 128'h0,
                   ct0: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, ct1: 128'h0};
        tbl[1] = '{mode: 1'b1, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   iv: 128'h000102030405060708090a0b0c0d0e0f, nblk: 2, stall: 0,
                   pt0: 128'h6bc1bee22e409f96e93d7e117393172a, pt1: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   ct0: 128'h7649abac8119b246cee98e9b12e9197d, ct1: 128'h5086cb9b507219ee95db113a917678b2};
        tbl[2] = tbl[1];
        tbl[2].stall = 20;
        tbl[3] = '{mode: 1'b0, key: 128'h2b7e151628aed2a6abf7158809cf4f3c, iv: 128'h0, nblk: 2, stall: 3,
                   pt0: 128'h6bc1bee22e409f96e93d7e117393172a, pt1: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   ct0: 128'h3ad77bb40d7a3660a89ecaf32466ef97, ct1: 128'hf5d3d58503b9699de785895a96fdbaaf};

        repeat (3) @(negedge clk);
        check_val("reset in_ready", in_ready, 0);
        check_val("reset out_valid", out_valid, 0);
        check_val("reset busy", busy, 0);
        check_val("reset done", done, 0);
        check_val("reset cipher_text", cipher_text, 0);
        reset = 1'b0;

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; num_blocks = BW'(1);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check_val("rst_prio busy", busy, 0);
        check_val("rst_prio in_ready", in_ready, 0);

        for (int i = 0; i < 4; i++) begin
            q_pt.delete(); q_exp.delete();
            q_pt.push_back(tbl[i].pt0);  q_pt.push_back(tbl[i].pt1);
            q_exp.push_back(tbl[i].ct0); q_exp.push_back(tbl[i].ct1);
            run_msg(tbl[i].mode, tbl[i].key, tbl[i].iv, tbl[i].nblk, tbl[i].stall, i % 2, 1'b0,
                    $sformatf("vec%0d", i));
        end

        run_msg(1'b1, tbl[1].key, tbl[1].iv, 0, 0, 0, 1'b0, "zero_blk");

        // Reset while block 0 of a two-block message is in the core.
        @(negedge clk);
        mode_cbc = 1'b1; key = tbl[1].key; vector = tbl[1].iv; num_blocks = BW'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; plain_text = tbl[1].pt0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_mid busy before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_mid in_ready", in_ready, 0);
        check_val("rst_mid out_valid", out_valid, 0);
        check_val("rst_mid busy", busy, 0);
        check_val("rst_mid done", done, 0);
        check_val("rst_mid cipher_text", cipher_text, 0);
        quiet_ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy || done) quiet_ok = 0;
        end
        check_val("rst_mid no stale output", quiet_ok, 1);

        q_pt.delete(); q_exp.delete();
        q_pt.push_back(tbl[1].pt0);  q_pt.push_back(tbl[1].pt1);
        q_exp.push_back(tbl[1].ct0); q_exp.push_back(tbl[1].ct1);
        run_msg(1'b1, tbl[1].key, tbl[1].iv, 2, 0, 0, 1'b0, "after_rst");

        // start pulses during ENCRYPT with a different key, mode and count must be ignored.
        run_msg(1'b1, tbl[1].key, tbl[1].iv, 2, 1, 0, 1'b1, "poke");

        for (int i = 0; i < 25; i++) begin
            m  = 1'($urandom);
            k  = rand128();
            iv = rand128();
            n  = $urandom_range(1, 4);
            prep_random(m, k, iv, n);
            run_msg(m, k, iv, n, $urandom_range(0, 3), $urandom_range(0, 2), 1'(i % 5 == 0),
                    $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
